prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 1, clock cycles each mosi bit is held (range 1..16).
REQ-002 SHALL have parameter TIMEOUT, default 255, cycles to wait for done_in after the last bit (range 1..65535).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request a transfer; sampled only in IDLE.
REQ-006 SHALL have port mode_sel  input  2  mode value to present to the processor during the transfer.
REQ-007 SHALL have port nbytes  input  4  transfer length minus one (0 = 1 byte, 15 = 16 bytes).
REQ-008 SHALL have port wr_data  input  8  next byte to transmit.
REQ-009 SHALL have port wr_valid  input  1  wr_data is valid.
REQ-010 SHALL have port wr_ready  output  1  loader accepts wr_data this cycle.
REQ-011 SHALL have port done_in  input  1  processor "done" status (processor uio_out[3]).
REQ-012 SHALL have port mode  output  2  processor mode bus (processor uio_in[1:0]).
REQ-013 SHALL have port mosi  output  1  serial data to the processor (processor uio_in[2]).
REQ-014 SHALL have port busy  output  1  transfer in progress.
REQ-015 SHALL have port finished  output  1  one-cycle pulse at transfer end.
REQ-016 SHALL have port err  output  1  last transfer timed out waiting for done_in.

Function
REQ-017 SHALL implement states IDLE, LOAD, SHIFT, WAIT_DONE, FIN.
REQ-018 IDLE: start=1 SHALL latch mode_sel and nbytes, clear err, go to LOAD; busy=1 and mode=latched value from the next cycle.
REQ-019 IDLE outputs SHALL be mode=2'b00, mosi=0, busy=0, wr_ready=0.
REQ-020 start while not in IDLE SHALL be ignored; mode_sel/nbytes changes after the latch SHALL have no effect.
REQ-021 LOAD: wr_ready=1 (combinational from state); wr_valid&wr_ready SHALL load the shift register and go to SHIFT next cycle; without wr_valid the loader SHALL wait indefinitely.
REQ-022 wr_ready SHALL be 0 in every state other than LOAD; wr_valid there SHALL be ignored.
REQ-023 SHIFT: mosi SHALL be the shift-register MSB, each bit held exactly CLKS_PER_BIT cycles, 8 bits MSB first, so a byte occupies 8*CLKS_PER_BIT consecutive cycles.
REQ-024 mosi SHALL be 0 outside SHIFT, including LOAD gaps between bytes.
REQ-025 After the 8th bit, the loader SHALL go to LOAD if bytes sent < nbytes+1, else to WAIT_DONE; the byte counter SHALL not wrap (16 bytes max).
REQ-026 WAIT_DONE: done_in=1 SHALL go to FIN with err=0; after TIMEOUT cycles without done_in, SHALL go to FIN with err=1.
REQ-027 done_in SHALL be ignored outside WAIT_DONE; done_in=1 already high on WAIT_DONE entry SHALL complete in that first cycle.
REQ-028 FIN SHALL last one cycle: finished=1, busy=1, mode held; then IDLE.
REQ-029 err SHALL hold its value until the next accepted start.
REQ-030 mode SHALL remain the latched value from LOAD through FIN inclusive, constant for the whole transfer.

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE, mode=00, mosi=0, busy=0, wr_ready=0, finished=0, err=0, and clear all counters and the shift register.
REQ-032 Reset asserted mid-transfer SHALL abort it with no finished pulse; after release the loader SHALL accept a new start normally.

Verification
REQ-033 CLKS_PER_BIT=1, start with mode_sel=2'b01, nbytes=0, byte 0xA5, done_in raised 3 cycles after last bit -> mode=01, mosi 1,0,1,0,0,1,0,1 on 8 consecutive cycles, one finished pulse, err=0, then mode=00.
REQ-034 nbytes=2, bytes 0x01,0xFF,0x80 with wr_valid held low 5 cycles before the second byte -> three correct MSB-first bytes, mosi=0 and wr_ready=1 during the gap.
REQ-035 CLKS_PER_BIT=4, byte 0xC3 -> each bit held exactly 4 cycles, 32-cycle byte.
REQ-036 TIMEOUT=10, done_in kept 0 -> finished pulse exactly 10 cycles after WAIT_DONE entry, err=1, and err cleared on the next start.
REQ-037 rst_n pulsed low during bit 4 of the 2nd byte of nbytes=3 -> all outputs reset at once, no finished pulse, next transfer with 0x5A correct.
REQ-038 start pulsed during SHIFT with a different mode_sel -> ignored; mode unchanged; single finished pulse.

Source files
------------

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Serial program loader. It presents a latched mode value to the
//               processor and shifts 1..16 bytes out MSB first on mosi, holding
//               each bit for CLKS_PER_BIT cycles. It then waits for the
//               processor's done_in, giving up after TIMEOUT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int CLKS_PER_BIT = 1,
    parameter int TIMEOUT      = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] mode_sel,
    input  logic [3:0] nbytes,
    input  logic [7:0] wr_data,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic       done_in,
    output logic [1:0] mode,
    output logic       mosi,
    output logic       busy,
    output logic       finished,
    output logic       err
);

    // State encoding
    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_load = 3'd1;
    localparam logic [2:0] c_st_shift = 3'd2;
    localparam logic [2:0] c_st_wait_done = 3'd3;
    localparam logic [2:0] c_st_fin = 3'd4;

    // Terminal counts for the bit-hold and done-wait counters
    localparam logic [3:0]  c_cpb_last = 4'(CLKS_PER_BIT - 1);
    localparam logic [15:0] c_to_last  = 16'(TIMEOUT - 1);

    logic [2:0]  r_state;
    logic [1:0]  r_mode;
    logic [3:0]  r_nbytes;
    logic [7:0]  r_shift;
    logic [3:0]  r_clk_cnt;
    logic [2:0]  r_bit_cnt;
    logic [3:0]  r_byte_cnt;
    logic [15:0] r_to_cnt;
    logic        r_mosi;
    logic        r_busy;
    logic        r_finished;
    logic        r_err;

    logic        w_bit_end;
    logic        w_byte_end;
    logic        w_last_byte;

    // A bit period ends on the last hold cycle; a byte ends with bit 7
    assign w_bit_end   = (r_clk_cnt == c_cpb_last);
    assign w_byte_end  = w_bit_end && (r_bit_cnt == 3'd7);
    // The byte counter indexes the byte in flight, so it never passes nbytes
    assign w_last_byte = (r_byte_cnt == r_nbytes);

    // The loader only accepts data while it is waiting for the next byte
    assign wr_ready = (r_state == c_st_load);

    assign mode     = r_mode;
    assign mosi     = r_mosi;
    assign busy     = r_busy;
    assign finished = r_finished;
    assign err      = r_err;

    // Transfer sequencer: mode latch, byte/bit shifting, done wait, end pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_st_idle;
            r_mode     <= 2'b00;
            r_nbytes   <= 4'd0;
            r_shift    <= 8'd0;
            r_clk_cnt  <= 4'd0;
            r_bit_cnt  <= 3'd0;
            r_byte_cnt <= 4'd0;
            r_to_cnt   <= 16'd0;
            r_mosi     <= 1'b0;
            r_busy     <= 1'b0;
            r_finished <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_mode     <= mode_sel;
                        r_nbytes   <= nbytes;
                        r_err      <= 1'b0;
                        r_busy     <= 1'b1;
                        r_byte_cnt <= 4'd0;
                        r_state    <= c_st_load;
                    end
                end

                c_st_load: begin
                    // Stall here for as long as the source has nothing to give
                    if (wr_valid) begin
                        r_shift   <= wr_data;
                        r_mosi    <= wr_data[7];
                        r_clk_cnt <= 4'd0;
                        r_bit_cnt <= 3'd0;
                        r_state   <= c_st_shift;
                    end
                end

                c_st_shift: begin
                    if (!w_bit_end) begin
                        r_clk_cnt <= r_clk_cnt + 4'd1;
                    end else if (!w_byte_end) begin
                        r_clk_cnt <= 4'd0;
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        r_shift   <= {r_shift[6:0], 1'b0};
                        r_mosi    <= r_shift[6];
                    end else begin
                        // Line returns low between bytes and after the last one
                        r_clk_cnt <= 4'd0;
                        r_shift   <= 8'd0;
                        r_mosi    <= 1'b0;
                        if (w_last_byte) begin
                            r_to_cnt <= 16'd0;
                            r_state  <= c_st_wait_done;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 4'd1;
                            r_state    <= c_st_load;
                        end
                    end
                end

                c_st_wait_done: begin
                    if (done_in) begin
                        r_err      <= 1'b0;
                        r_finished <= 1'b1;
                        r_state    <= c_st_fin;
                    end else if (r_to_cnt == c_to_last) begin
                        r_err      <= 1'b1;
                        r_finished <= 1'b1;
                        r_state    <= c_st_fin;
                    end else begin
                        r_to_cnt <= r_to_cnt + 16'd1;
                    end
                end

                c_st_fin: begin
                    // err is left alone so the outcome stays visible in IDLE
                    r_finished <= 1'b0;
                    r_busy     <= 1'b0;
                    r_mode     <= 2'b00;
                    r_state    <= c_st_idle;
                end

                default: begin
                    r_state    <= c_st_idle;
                    r_mode     <= 2'b00;
                    r_mosi     <= 1'b0;
                    r_busy     <= 1'b0;
                    r_finished <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader
// Description : Randomised self-checking bench for prog_loader. Each transfer
//               is described by its bytes, source gaps and done_in delay. The
//               expected waveform is derived from those: every byte is 8*CPB
//               cycles of MSB-first bits, and the done wait lasts min(d+1, TO)
//               cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    localparam int CPB = 4;
    localparam int TO  = 10;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic       start    = 1'b0;
    logic [1:0] mode_sel = 2'b00;
    logic [3:0] nbytes   = 4'd0;
    logic [7:0] wr_data  = 8'd0;
    logic       wr_valid = 1'b0;
    logic       done_in  = 1'b0;
    logic       wr_ready;
    logic [1:0] mode;
    logic       mosi;
    logic       busy;
    logic       finished;
    logic       err;

    int   n_vec   = 0;
    int   n_err   = 0;
    logic exp_err = 1'b0;

    logic [7:0] t_bytes [16];
    int         t_gaps  [16];

    prog_loader #(
        .CLKS_PER_BIT(CPB),
        .TIMEOUT     (TO)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mode_sel (mode_sel),
        .nbytes   (nbytes),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .done_in  (done_in),
        .mode     (mode),
        .mosi     (mosi),
        .busy     (busy),
        .finished (finished),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, 16'(busy), 16'd0);
        chk({tag, "_mode"}, 16'(mode), 16'd0);
        chk({tag, "_mosi"}, 16'(mosi), 16'd0);
        chk({tag, "_wr_ready"}, 16'(wr_ready), 16'd0);
        chk({tag, "_finished"}, 16'(finished), 16'd0);
        chk({tag, "_err"}, 16'(err), 16'(exp_err));
    endtask

    task automatic check_active(input string tag, input logic [1:0] m,
                                input logic exp_rdy, input logic exp_mosi);
        chk({tag, "_busy"}, 16'(busy), 16'd1);
        chk({tag, "_mode"}, 16'(mode), 16'(m));
        chk({tag, "_mosi"}, 16'(mosi), 16'(exp_mosi));
        chk({tag, "_wr_ready"}, 16'(wr_ready), 16'(exp_rdy));
        chk({tag, "_finished"}, 16'(finished), 16'd0);
        chk({tag, "_err"}, 16'(err), 16'd0);
    endtask

    task automatic idle_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            check_idle("idle");
            start    = 1'b0;
            wr_valid = 1'($urandom_range(0, 1));
            done_in  = 1'($urandom_range(0, 1));
            mode_sel = 2'($urandom_range(0, 3));
            nbytes   = 4'($urandom_range(0, 15));
            step();
        end
        wr_valid = 1'b0;
        done_in  = 1'b0;
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear before any edge
    task automatic mid_reset();
        #2 rst_n = 1'b0;
        #1;
        exp_err = 1'b0;
        check_idle("rst_now");
        start    = 1'b0;
        wr_valid = 1'b0;
        done_in  = 1'b0;
        step();
        check_idle("rst_hold");
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check_idle("rst_after");
        end
    endtask

    // One transfer from the current negedge (DUT idle). d = number of WAIT
    // cycles with done_in low before it rises; d >= TO means a timeout.
    task automatic run_transfer(input logic [1:0] m, input int nb, input int d,
                                input int abort_byte);
        int   w;
        logic e;
        w = (d < TO) ? d + 1 : TO;
        e = (d >= TO);
        start    = 1'b1;
        mode_sel = m;
        nbytes   = 4'(nb);
        wr_valid = 1'b0;
        done_in  = 1'b0;
        step();
        start   = 1'b0;
        exp_err = 1'b0;
        for (int i = 0; i <= nb; i++) begin
            for (int g = 0; g < t_gaps[i]; g++) begin
                check_active("gap", m, 1'b1, 1'b0);
                wr_valid = 1'b0;
                wr_data  = 8'($urandom_range(0, 255));
                start    = 1'($urandom_range(0, 1));
                mode_sel = 2'($urandom_range(0, 3));
                nbytes   = 4'($urandom_range(0, 15));
                done_in  = 1'($urandom_range(0, 1));
                step();
            end
            check_active("load", m, 1'b1, 1'b0);
            wr_valid = 1'b1;
            wr_data  = t_bytes[i];
            start    = 1'b0;
            step();
            for (int k = 0; k < 8 * CPB; k++) begin
                if (i == abort_byte && k == 4 * CPB) begin
                    mid_reset();
                    return;
                end
                check_active("shift", m, 1'b0, t_bytes[i][7 - k / CPB]);
                wr_valid = 1'($urandom_range(0, 1));
                wr_data  = 8'($urandom_range(0, 255));
                start    = 1'($urandom_range(0, 1));
                mode_sel = 2'($urandom_range(0, 3));
                nbytes   = 4'($urandom_range(0, 15));
                done_in  = 1'($urandom_range(0, 1));
                if (k == 8 * CPB - 1) begin
                    wr_valid = 1'b0;
                    done_in  = (d == 0);
                end
                step();
            end
        end
        for (int j = 0; j < w; j++) begin
            check_active("wait", m, 1'b0, 1'b0);
            start    = 1'b0;
            wr_valid = 1'($urandom_range(0, 1));
            done_in  = (j >= d);
            step();
        end
        exp_err = e;
        chk("fin_finished", 16'(finished), 16'd1);
        chk("fin_busy", 16'(busy), 16'd1);
        chk("fin_mode", 16'(mode), 16'(m));
        chk("fin_mosi", 16'(mosi), 16'd0);
        chk("fin_wr_ready", 16'(wr_ready), 16'd0);
        chk("fin_err", 16'(err), 16'(e));
        start    = 1'b0;
        wr_valid = 1'b0;
        done_in  = 1'($urandom_range(0, 1));
        step();
        check_idle("post");
        done_in = 1'b0;
    endtask

    task automatic clear_gaps();
        for (int i = 0; i < 16; i++) t_gaps[i] = 0;
    endtask

    initial begin
        clear_gaps();
        #1 rst_n = 1'b0;
        step();
        check_idle("reset");
        step();
        rst_n = 1'b1;
        idle_cycles(2);

        // Single byte 0xA5, done three cycles after the last bit
        t_bytes[0] = 8'hA5;
        run_transfer(2'b01, 0, 3, -1);
        idle_cycles(2);

        // Three bytes with a five-cycle source gap before the second
        t_bytes[0] = 8'h01; t_bytes[1] = 8'hFF; t_bytes[2] = 8'h80;
        t_gaps[1] = 5;
        run_transfer(2'b10, 2, 2, -1);
        clear_gaps();
        idle_cycles(1);

        // 0xC3 with done already high on WAIT_DONE entry
        t_bytes[0] = 8'hC3;
        run_transfer(2'b11, 0, 0, -1);

        // Latest possible done before the timeout
        t_bytes[0] = 8'h3C;
        run_transfer(2'b01, 0, TO - 1, -1);

        // Timeout: err must stay set through idle and clear on the next start
        t_bytes[0] = 8'h96; t_bytes[1] = 8'h69;
        run_transfer(2'b11, 1, TO + 3, -1);
        idle_cycles(3);

        // Reset during bit 4 of the second byte of a four-byte transfer
        t_bytes[0] = 8'h12; t_bytes[1] = 8'h34; t_bytes[2] = 8'h56; t_bytes[3] = 8'h78;
        run_transfer(2'b10, 3, 1, 1);
        t_bytes[0] = 8'h5A;
        run_transfer(2'b01, 0, 1, -1);

        // Randomised transfers
        for (int t = 0; t < 30; t++) begin
            int nb;
            int d;
            nb = $urandom_range(0, 15);
            d  = $urandom_range(0, TO + 4);
            for (int i = 0; i < 16; i++) begin
                t_bytes[i] = 8'($urandom_range(0, 255));
                t_gaps[i]  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            end
            run_transfer(2'($urandom_range(0, 3)), nb, d, -1);
            idle_cycles($urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
